ref_sched: RTL

REF_SCHED -- requirements
Module: ref_sched

---
 rtl/sdr_pkg.sv | 12 +
 rtl/ref_tick.sv | 38 +++
 rtl/ref_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// rtl/sdr_pkg.sv - shared refresh-scheduler state encoding and default constants
package sdr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REF  = 1'b1
    } ref_state_t;

    localparam int REF_W_DEF   = 12;
    localparam int MAXPOST_DEF = 8;

endpackage

// File: rtl/ref_tick.sv
// rtl/ref_tick.sv - refresh interval counter producing a one-cycle tick
module ref_tick #(
    parameter int REF_W = 12
) (
    input  logic             mclk_i,
    input  logic             s_reset_i,
    input  logic             init_done_i,
    input  logic [REF_W-1:0] sdr_rfrsh_i,
    output logic             tick_o
);

    logic [REF_W-1:0] cnt_q;
    logic [REF_W-1:0] cnt_d;

    // Count while initialised and enabled; wrap and tick at interval-1, park at 0 otherwise.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!init_done_i || (sdr_rfrsh_i == '0)) begin
            cnt_d = '0;
        end else if (cnt_q == (sdr_rfrsh_i - REF_W'(1))) begin
            tick_o = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + REF_W'(1);
        end
    end

    // Interval counter register.
    always_ff @(posedge mclk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ref_sched.sv
// rtl/ref_sched.sv - SDRAM auto-refresh scheduler with host arbitration (optional stats: REF_SCHED_STAT_EN)
module ref_sched
    import sdr_pkg::*;
#(
    parameter int REF_W   = REF_W_DEF,
    parameter int MAXPOST = MAXPOST_DEF,
    parameter int PW      = $clog2(MAXPOST + 1)
) (
    input  logic             mclk,
    input  logic             s_reset,
    input  logic             init_done,
    input  logic [REF_W-1:0] sdr_rfrsh,
    input  logic [PW-1:0]    sdr_rfmax,
    input  logic             sdr_req,
    input  logic             sdr_req_wr_n,
    input  logic             req_ack,
    input  logic             trca_end,
    output logic             ref_req,
    output logic             ref_urgent,
    output logic [PW-1:0]    ref_pend,
    output logic             ref_ovf,
    output logic             wen,
    output logic             ren,
    output logic             sdr_req_wr_nL
`ifdef REF_SCHED_STAT_EN
    ,
    output logic [15:0]      ref_urg_cnt
`endif
);

    localparam logic [PW-1:0] PEND_MAX = PW'(MAXPOST);

    ref_state_t    state_q, state_d;
    logic [PW-1:0] pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          wrnl_q, wrnl_d;
    logic          req_dly_q;
    logic          tick;
    logic          dec;
    logic          req_rise;

    ref_tick #(
        .REF_W (REF_W)
    ) u_tick (
        .mclk_i      (mclk),
        .s_reset_i   (s_reset),
        .init_done_i (init_done),
        .sdr_rfrsh_i (sdr_rfrsh),
        .tick_o      (tick)
    );

    assign dec        = trca_end && (state_q == ST_REF);
    assign req_rise   = sdr_req && !req_dly_q;
    assign ref_urgent = (pend_q >= sdr_rfmax);
    assign ref_req    = (state_q == ST_REF);
    assign ref_pend   = pend_q;
    assign ref_ovf    = ovf_q;
    assign sdr_req_wr_nL = wrnl_q;
    assign wen = busy_q && sdr_req && init_done && !wrnl_q && (state_q == ST_IDLE) && !ref_urgent;
    assign ren = busy_q && sdr_req && init_done &&  wrnl_q && (state_q == ST_IDLE) && !ref_urgent;

    // Owed-refresh bookkeeping: a coincident tick and completion cancel out.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PW'(1);
            end
        end else if (dec && !tick && (pend_q != '0)) begin
            pend_d = pend_q - PW'(1);
        end
        if (!init_done) begin
            pend_d = '0;
        end
    end

    // Refresh FSM: enter when owed and host idle (or urgent); burst until drained or host wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if ((pend_q != '0) && (!busy_q || ref_urgent)) begin
                    state_d = ST_REF;
                end
            end
            ST_REF: begin
                if (trca_end && ((pend_d == '0) || (busy_q && (pend_d < sdr_rfmax)))) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!init_done) begin
            state_d = ST_IDLE;
        end
    end

    // Host request tracking: acknowledge beats a new rising edge.
    always_comb begin
        busy_d = busy_q;
        wrnl_d = wrnl_q;
        if (req_rise) begin
            wrnl_d = sdr_req_wr_n;
        end
        if (req_ack) begin
            busy_d = 1'b0;
        end else if (req_rise) begin
            busy_d = 1'b1;
        end
        if (!init_done) begin
            busy_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge mclk or posedge s_reset) begin
        if (s_reset) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            wrnl_q    <= 1'b0;
            req_dly_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            wrnl_q    <= wrnl_d;
            req_dly_q <= sdr_req;
        end
    end

`ifdef REF_SCHED_STAT_EN
    logic [15:0] urg_cnt_q;

    assign ref_urg_cnt = urg_cnt_q;

    // Saturating count of refresh entries forced by urgency.
    always_ff @(posedge mclk or posedge s_reset) begin
        if (s_reset) begin
            urg_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && (state_d == ST_REF) && ref_urgent && (urg_cnt_q != 16'hFFFF)) begin
            urg_cnt_q <= urg_cnt_q + 16'd1;
        end
    end
`endif

endmodule
